// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Stage shadow record plus forwarding-select codes.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_REG_AW-1:0] rs1;
    logic [DEF_REG_AW-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

  // A record writes a real register (x0 never counts).
  function automatic logic is_writer(stage_rec_t r);
    return r.valid && r.reg_write && (r.rd != '0);
  endfunction

  // Operand source for one EX operand; MEM beats WB, MEM loads never forward.
  function automatic logic [1:0] fwd_sel(
    stage_rec_t            ex,
    stage_rec_t            mem,
    stage_rec_t            wb,
    logic                  use_src,
    logic [DEF_REG_AW-1:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex.valid && use_src) begin
      if (is_writer(mem) && !mem.mem_read && (mem.rd == src)) begin
        sel = FWD_MEM;
      end else if (is_writer(wb) && (wb.rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline-stage record.
// Sync clear wins; bubble invalidates the incoming record.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  // Next record: the upstream record, squashed when bubbled.
  always_comb begin
    rec_d = d;
    if (bubble) begin
      rec_d.valid = 1'b0;
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign q = rec_q;

endmodule

// File: rtl/hazard_ctl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Shadows EX/MEM/WB, issues stall/bubble/flush and EX forward selects.
module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              ex_pcSel,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_rec_t id_rec;
  stage_rec_t ex_q;
  stage_rec_t mem_q;
  stage_rec_t wb_q;

  logic lu_raw;
  logic lu;

  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;

  // Pack the ID-stage inputs into a stage record.
  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rd        = id_rd;
    id_rec.rs1       = id_rs1;
    id_rec.rs2       = id_rs2;
    id_rec.use_rs1   = id_use_rs1;
    id_rec.use_rs2   = id_use_rs2;
    id_rec.reg_write = id_regWrite;
    id_rec.mem_read  = id_memRead;
  end

  hazard_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (~id_valid | bubble_id_ex),
    .d      (id_rec),
    .q      (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Load-use detect; masked while reset is pending on the shadows.
  always_comb begin
    lu_raw = is_writer(ex_q) && ex_q.mem_read && id_valid &&
             ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
              (id_use_rs2 && (id_rs2 == ex_q.rd)));
    lu     = lu_raw && !rst;
  end

  // Pipeline commands: a taken branch squashes the dependent instruction.
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    priority case (1'b1)
      ex_pcSel: begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      lu: begin
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      default: ;
    endcase
  end

  // EX operand forwarding selects.
  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (!rst) begin
      fwdA = fwd_sel(ex_q, mem_q, wb_q, ex_q.use_rs1, ex_q.rs1);
      fwdB = fwd_sel(ex_q, mem_q, wb_q, ex_q.use_rs2, ex_q.rs2);
    end
  end

  // Saturating event counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && !ex_pcSel && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ex_pcSel && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed self-checking bench for hazard_ctl.
// Counters built 4 bits wide to reach saturation quickly.
module tb_hazard_ctl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [AW-1:0] id_rd;
  logic          id_regWrite;
  logic          id_memRead;
  logic          ex_pcSel;
  logic          stall_if_id;
  logic          bubble_id_ex;
  logic          flush_if_id;
  logic [1:0]    fwdA;
  logic [1:0]    fwdB;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int errs;
  int checks;

  hazard_ctl #(
    .REG_AW (AW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regWrite  (id_regWrite),
    .id_memRead   (id_memRead),
    .ex_pcSel     (ex_pcSel),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .fwdA         (fwdA),
    .fwdB         (fwdB),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic u1,
                        input logic u2, input logic [AW-1:0] rd,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regWrite = rw;
    id_memRead  = mr;
    #1;
  endtask

  task automatic nop_id();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmds(input string tag, input logic s,
                      input logic b, input logic f);
    chk({tag, ".stall"}, 32'(stall_if_id), 32'(s));
    chk({tag, ".bubble"}, 32'(bubble_id_ex), 32'(b));
    chk({tag, ".flush"}, 32'(flush_if_id), 32'(f));
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    rst      = 1'b1;
    ex_pcSel = 1'b0;
    nop_id();
    tick();
    tick();
    rst = 1'b0;
    #1;
    cmds("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.fwdA", 32'(fwdA), 32'd0);
    chk("rst.fwdB", 32'(fwdB), 32'd0);
    chk("rst.scnt", 32'(stall_cnt), 32'd0);
    chk("rst.fcnt", 32'(flush_cnt), 32'd0);

    // load-use on rs1, then forward the load from WB
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    cmds("lu", 1'b1, 1'b1, 1'b0);
    chk("lu.scnt0", 32'(stall_cnt), 32'd0);
    tick();
    cmds("lu_after", 1'b0, 1'b0, 1'b0);
    chk("lu.scnt1", 32'(stall_cnt), 32'd1);
    tick();
    nop_id();
    chk("lu.fwdA_wb", 32'(fwdA), 32'd2);
    chk("lu.fwdB_rf", 32'(fwdB), 32'd0);
    tick(); tick(); tick();

    // MEM and WB both write x7: MEM wins
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cmds("fwd_nolu", 1'b0, 1'b0, 1'b0);
    tick();
    nop_id();
    chk("pri.fwdA", 32'(fwdA), 32'd1);
    chk("pri.fwdB", 32'(fwdB), 32'd1);
    tick(); tick(); tick();

    // only WB writes x7
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    nop_id();
    tick();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    nop_id();
    chk("wb.fwdA", 32'(fwdA), 32'd2);
    chk("wb.fwdB", 32'(fwdB), 32'd2);
    tick(); tick(); tick();

    // x0 is never a hazard or forward source
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    cmds("x0_lu", 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    nop_id();
    chk("x0.fwdA", 32'(fwdA), 32'd0);
    chk("x0.fwdB", 32'(fwdB), 32'd0);
    chk("x0.scnt", 32'(stall_cnt), 32'd1);
    tick(); tick(); tick();

    // rs2 load-use needs use_rs2
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    cmds("rs2_nouse", 1'b0, 1'b0, 1'b0);
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    cmds("rs2_lu", 1'b1, 1'b1, 1'b0);
    tick();
    nop_id();
    chk("rs2.scnt", 32'(stall_cnt), 32'd2);
    tick(); tick(); tick();

    // branch taken over a load-use
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 5'd9, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0);
    ex_pcSel = 1'b1;
    #1;
    cmds("br_lu", 1'b0, 1'b1, 1'b1);
    tick();
    ex_pcSel = 1'b0;
    nop_id();
    chk("br.fcnt", 32'(flush_cnt), 32'd1);
    chk("br.scnt", 32'(stall_cnt), 32'd2);
    cmds("br_after", 1'b0, 1'b0, 1'b0);

    // flush counter saturation
    ex_pcSel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    ex_pcSel = 1'b0;
    #1;
    chk("sat.fcnt", 32'(flush_cnt), 32'd15);
    chk("sat.scnt", 32'(stall_cnt), 32'd2);
    tick(); tick(); tick();

    // reset asserted during the load-use cycle
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    cmds("pre_rst_lu", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    cmds("rst_cycle", 1'b0, 1'b0, 1'b0);
    ex_pcSel = 1'b1;
    #1;
    cmds("rst_br", 1'b0, 1'b1, 1'b1);
    ex_pcSel = 1'b0;
    #1;
    tick();
    rst = 1'b0;
    #1;
    cmds("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.fwdA", 32'(fwdA), 32'd0);
    chk("post_rst.scnt", 32'(stall_cnt), 32'd0);
    chk("post_rst.fcnt", 32'(flush_cnt), 32'd0);
    tick();
    nop_id();
    chk("post_rst.fwdA2", 32'(fwdA), 32'd0);
    chk("post_rst.scnt2", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
